key_multi_debounce: RTL

Parametrised successor to the single-flag key scanner. It debounces `KEY_WIDTH` keys independently, with a 2-flop synchroniser and its own counter per key. Each key produces press and release event pulses, a one-shot long-press pulse and an optional auto-repeat pulse train. It sits between board push-buttons and user control logic, such as threshold or mode stepping in the image pipelines. It also keeps the `key_flag`/`key_value` pair, so existing consumers still work.

---
 rtl/key_multi_debounce_if.sv | 29 ++
 rtl/key_multi_debounce.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/key_multi_debounce_if.sv
// Key pins plus per-key debounced level and event pulses for key_multi_debounce.
// master = the debouncer (samples pins, produces events); slave = the consumer that owns the pins.
interface key_multi_debounce_if #(
  parameter int KEY_WIDTH = 4
);
  // Events are single-cycle pulses with no back-pressure. A consumer must act on the cycle
  // the pulse is high. key_value holds the last press vector until the next key_flag.
  logic [KEY_WIDTH-1:0]   key_data;
  logic [KEY_WIDTH-1:0]   key_state;
  logic [KEY_WIDTH-1:0]   key_press;
  logic [KEY_WIDTH-1:0]   key_release;
  logic [KEY_WIDTH-1:0]   key_long;
  logic [KEY_WIDTH-1:0]   key_repeat;
  logic                   key_flag;
  logic [KEY_WIDTH-1:0]   key_value;
  logic [2*KEY_WIDTH-1:0] dbg_state;

  modport master (
    input  key_data,
    output key_state, key_press, key_release, key_long, key_repeat,
    output key_flag, key_value, dbg_state
  );

  modport slave (
    output key_data,
    input  key_state, key_press, key_release, key_long, key_repeat,
    input  key_flag, key_value, dbg_state
  );
endinterface

// File: rtl/key_multi_debounce.sv
// Per-key synchroniser, debounce counter and press/long/repeat FSM.
// The auto-repeat pulse train exists only when the macro KEY_REPEAT_EN is defined.
module key_multi_debounce #(
  parameter int KEY_WIDTH       = 4,
  parameter int KEY_ACTIVE_LOW  = 1,
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int LONG_CYCLES     = 50_000_000,
  parameter int REPEAT_CYCLES   = 10_000_000
) (
  input logic                 clk,
  input logic                 rst_n,
  key_multi_debounce_if.master kif
);
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_HELD   = 2'd1,
    ST_REPEAT = 2'd2
  } key_st_e;

  localparam int DW   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int HMAX = (LONG_CYCLES > REPEAT_CYCLES) ? LONG_CYCLES : REPEAT_CYCLES;
  localparam int HW   = $clog2(HMAX);
  localparam logic [DW-1:0] DB_LAST   = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [HW-1:0] LONG_LAST = HW'(LONG_CYCLES - 1);
`ifdef KEY_REPEAT_EN
  localparam logic [HW-1:0] REP_LAST  = HW'(REPEAT_CYCLES - 1);
`endif
  localparam logic [KEY_WIDTH-1:0] IDLE_LVL = (KEY_ACTIVE_LOW != 0) ? '1 : '0;

  logic [KEY_WIDTH-1:0] sync1_q, sync2_q;
  logic [KEY_WIDTH-1:0] raw, chg, toggle, press_ev, rel_ev;
  logic [KEY_WIDTH-1:0] state_q;
  logic [KEY_WIDTH-1:0] press_d, release_d, long_d, repeat_d;
  logic [KEY_WIDTH-1:0] press_q, release_q, long_q, repeat_q, value_q;
  logic                 flag_q;
  logic [DW-1:0]        db_cnt_q [KEY_WIDTH];
  logic [DW-1:0]        db_cnt_d [KEY_WIDTH];
  logic [HW-1:0]        hold_q   [KEY_WIDTH];
  logic [HW-1:0]        hold_d   [KEY_WIDTH];
  key_st_e              st_q     [KEY_WIDTH];
  key_st_e              st_d     [KEY_WIDTH];
  logic [2*KEY_WIDTH-1:0] dbg;

  assign raw = sync2_q ^ IDLE_LVL;
  // Change detection looks one stage ahead (sync1 vs sync2) so the counter restarts the
  // cycle the new level reaches raw, not one cycle later.
  assign chg = sync1_q ^ sync2_q;

  always_comb begin : debounce_comb
    toggle = '0;
    for (int i = 0; i < KEY_WIDTH; i++) begin
      db_cnt_d[i] = '0;
      if ((raw[i] != state_q[i]) && !chg[i]) begin
        if (db_cnt_q[i] == DB_LAST) toggle[i] = 1'b1;
        else                        db_cnt_d[i] = db_cnt_q[i] + DW'(1);
      end
    end
  end

  assign press_ev = toggle & ~state_q;
  assign rel_ev   = toggle & state_q;

  always_comb begin : fsm_comb
    press_d   = '0;
    release_d = '0;
    long_d    = '0;
    repeat_d  = '0;
    for (int i = 0; i < KEY_WIDTH; i++) begin
      st_d[i]   = st_q[i];
      hold_d[i] = hold_q[i];
      case (st_q[i])
        ST_IDLE: begin
          if (press_ev[i]) begin
            st_d[i]    = ST_HELD;
            hold_d[i]  = '0;
            press_d[i] = 1'b1;
          end
        end
        ST_HELD: begin
          // Release takes priority over a terminal count on the same edge.
          if (rel_ev[i]) begin
            st_d[i]      = ST_IDLE;
            hold_d[i]    = '0;
            release_d[i] = 1'b1;
          end else if (hold_q[i] == LONG_LAST) begin
            st_d[i]   = ST_REPEAT;
            hold_d[i] = '0;
            long_d[i] = 1'b1;
          end else begin
            hold_d[i] = hold_q[i] + HW'(1);
          end
        end
        ST_REPEAT: begin
          if (rel_ev[i]) begin
            st_d[i]      = ST_IDLE;
            hold_d[i]    = '0;
            release_d[i] = 1'b1;
          end else begin
`ifdef KEY_REPEAT_EN
            if (hold_q[i] == REP_LAST) begin
              hold_d[i]   = '0;
              repeat_d[i] = 1'b1;
            end else begin
              hold_d[i] = hold_q[i] + HW'(1);
            end
`else
            hold_d[i] = hold_q[i];
`endif
          end
        end
        default: begin
          st_d[i]   = ST_IDLE;
          hold_d[i] = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q   <= IDLE_LVL;
      sync2_q   <= IDLE_LVL;
      state_q   <= '0;
      press_q   <= '0;
      release_q <= '0;
      long_q    <= '0;
      repeat_q  <= '0;
      flag_q    <= 1'b0;
      value_q   <= '0;
      for (int i = 0; i < KEY_WIDTH; i++) begin
        db_cnt_q[i] <= '0;
        hold_q[i]   <= '0;
        st_q[i]     <= ST_IDLE;
      end
    end else begin
      sync1_q   <= kif.key_data;
      sync2_q   <= sync1_q;
      state_q   <= state_q ^ toggle;
      press_q   <= press_d;
      release_q <= release_d;
      long_q    <= long_d;
      repeat_q  <= repeat_d;
      flag_q    <= |press_q;
      if (|press_q) value_q <= press_q;
      for (int i = 0; i < KEY_WIDTH; i++) begin
        db_cnt_q[i] <= db_cnt_d[i];
        hold_q[i]   <= hold_d[i];
        st_q[i]     <= st_d[i];
      end
    end
  end

  always_comb begin : dbg_pack
    dbg = '0;
    for (int i = 0; i < KEY_WIDTH; i++) dbg[2*i +: 2] = st_q[i];
  end

  assign kif.key_state   = state_q;
  assign kif.key_press   = press_q;
  assign kif.key_release = release_q;
  assign kif.key_long    = long_q;
  assign kif.key_repeat  = repeat_q;
  assign kif.key_flag    = flag_q;
  assign kif.key_value   = value_q;
  assign kif.dbg_state   = dbg;
endmodule
